// File: rtl/slice_stream_sequencer.sv
// Line sequencer: feeds DEPTH buffered lines to the slice core one at a time with a
// start/done handshake, captures each result, and aborts a run if a line exceeds TIMEOUT.
module slice_stream_sequencer #(
  parameter int WIDTH   = 25,
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 1024,
  parameter int TMR_W   = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_we,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [WIDTH-1:0]  in_data,
  output logic [WIDTH-1:0]  core_line,
  output logic [ADDR_W-1:0] core_index,
  output logic              core_start,
  input  logic              core_done,
  input  logic [WIDTH-1:0]  core_result,
  input  logic [ADDR_W-1:0] out_addr,
  output logic [WIDTH-1:0]  out_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   lines_done
);

  // Handshake: core_start is a one-cycle pulse marking core_line/core_index valid; the
  // core answers with a one-cycle core_done carrying core_result, accepted only in WAIT
  // and never in the same cycle as core_start.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);

  logic [WIDTH-1:0] buf_in  [DEPTH];
  logic [WIDTH-1:0] buf_out [DEPTH];

  state_t            state_q,      state_d;
  logic [ADDR_W-1:0] idx_q,        idx_d;
  logic [TMR_W-1:0]  timer_q,      timer_d;
  logic [WIDTH-1:0]  core_line_q,  core_line_d;
  logic [ADDR_W-1:0] core_index_q, core_index_d;
  logic              core_start_q, core_start_d;
  logic              busy_q,       busy_d;
  logic              done_q,       done_d;
  logic              err_q,        err_d;
  logic [ADDR_W:0]   lines_done_q, lines_done_d;

  logic in_wr_en;
  logic out_wr_en;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    timer_d      = timer_q;
    core_line_d  = core_line_q;
    core_index_d = core_index_q;
    core_start_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;
    lines_done_d = lines_done_q;
    out_wr_en    = 1'b0;
    // Input buffer is frozen while a run is active; a reset cycle writes nothing.
    in_wr_en     = in_we && !busy_q && !rst;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d        = '0;
          err_d        = 1'b0;
          lines_done_d = '0;
          busy_d       = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        core_line_d  = buf_in[idx_q];
        core_index_d = idx_q;
        core_start_d = 1'b1;
        timer_d      = '0;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        if (core_done && !core_start_q) begin
          out_wr_en    = !rst;
          lines_done_d = lines_done_q + 1'b1;
          // Finishing on the last index keeps idx from ever wrapping.
          if (idx_q == LAST_IDX) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_ISSUE;
          end
        end else if (timer_q == TMR_LAST) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      timer_q      <= '0;
      core_line_q  <= '0;
      core_index_q <= '0;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      lines_done_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      core_line_q  <= core_line_d;
      core_index_q <= core_index_d;
      core_start_q <= core_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      lines_done_q <= lines_done_d;
    end
  end

  // Buffer storage carries no reset; enables already exclude the reset cycle.
  always_ff @(posedge clk) begin
    if (in_wr_en) begin
      buf_in[in_addr] <= in_data;
    end
    if (out_wr_en) begin
      buf_out[idx_q] <= core_result;
    end
  end

  assign out_data   = buf_out[out_addr];
  assign core_line  = core_line_q;
  assign core_index = core_index_q;
  assign core_start = core_start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign lines_done = lines_done_q;

endmodule
